axi_ddsv2_regs_slave: RTL and testbench

AXI4-Lite responder holding the DDS v2 property registers. It sits between the block-design AXI interconnect (driven by the VIP master in simulation, the PS in hardware) and the DDS core. It accepts single-beat writes and reads and exposes the register contents plus per-register update strobes to the core. It is the slave end of the AXI4-Lite write/read sequences the master bench issues.

---
 rtl/axi_ddsv2_regs_pkg.sv | 45 ++++
 rtl/axi_ddsv2_regs_if.sv | 63 ++++++
 rtl/axi_ddsv2_regs_bank.sv | 76 +++++++
 rtl/axi_ddsv2_regs_slave.sv | 192 +++++++++++++++++++
 tb/tb_axi_ddsv2_regs_slave.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_ddsv2_regs_pkg.sv
// ============================================================================
// Module   : axi_ddsv2_regs_pkg
// Purpose  : Shared constants, response codes, channel FSM state types and the
//            byte-strobe merge helper for the DDS v2 AXI4-Lite register slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_ddsv2_regs_pkg;

    localparam int AXI_DATA_WIDTH = 32;
    localparam int STRB_WIDTH     = AXI_DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // Byte lanes with a set strobe take the new data, the rest keep the old.
    function automatic logic [AXI_DATA_WIDTH-1:0] strb_merge(
        input logic [AXI_DATA_WIDTH-1:0] old_val,
        input logic [AXI_DATA_WIDTH-1:0] new_val,
        input logic [STRB_WIDTH-1:0]     strb
    );
        logic [AXI_DATA_WIDTH-1:0] result;
        result = old_val;
        for (int b = 0; b < STRB_WIDTH; b++) begin
            if (strb[b]) begin
                result[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_ddsv2_regs_if.sv
// ============================================================================
// Module   : axi_ddsv2_regs_if
// Purpose  : AXI4-Lite bus bundle (AW, W, B, AR, R channels) between the
//            interconnect master and the DDS v2 register slave.
// Ports    : none; signals are grouped into master and slave modports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_ddsv2_regs_if #(
    parameter int ADDR_WIDTH = 5
) ();
    import axi_ddsv2_regs_pkg::*;

    logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR;
    logic [2:0]                S_AXI_AWPROT;
    logic                      S_AXI_AWVALID;
    logic                      S_AXI_AWREADY;
    logic [AXI_DATA_WIDTH-1:0] S_AXI_WDATA;
    logic [STRB_WIDTH-1:0]     S_AXI_WSTRB;
    logic                      S_AXI_WVALID;
    logic                      S_AXI_WREADY;
    logic [1:0]                S_AXI_BRESP;
    logic                      S_AXI_BVALID;
    logic                      S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR;
    logic [2:0]                S_AXI_ARPROT;
    logic                      S_AXI_ARVALID;
    logic                      S_AXI_ARREADY;
    logic [AXI_DATA_WIDTH-1:0] S_AXI_RDATA;
    logic [1:0]                S_AXI_RRESP;
    logic                      S_AXI_RVALID;
    logic                      S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

endinterface

`default_nettype wire

// File: rtl/axi_ddsv2_regs_bank.sv
// ============================================================================
// Module   : axi_ddsv2_regs_bank
// Purpose  : DDS v2 property register array with byte-strobe write merge,
//            per-register update strobes and a combinational read mux.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_wr_en/idx/data/strb - committed write (already range-checked)
//            i_rd_idx, o_rd_data   - read index and current contents (0 if
//                                    the index matches no register)
//            o_reg_out       - flat register contents, reg i at [32i+31:32i]
//            o_reg_wr        - one-cycle pulse after reg i is written
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_ddsv2_regs_bank
    import axi_ddsv2_regs_pkg::*;
#(
    parameter int unsigned             NUM_REGS  = 4,
    parameter int                      IDX_W     = 3,
    parameter logic [AXI_DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    input  wire logic                           i_wr_en,
    input  wire logic [IDX_W-1:0]               i_wr_idx,
    input  wire logic [AXI_DATA_WIDTH-1:0]      i_wr_data,
    input  wire logic [STRB_WIDTH-1:0]          i_wr_strb,
    input  wire logic [IDX_W-1:0]               i_rd_idx,
    output logic      [AXI_DATA_WIDTH-1:0]      o_rd_data,
    output logic      [NUM_REGS*AXI_DATA_WIDTH-1:0] o_reg_out,
    output logic      [NUM_REGS-1:0]            o_reg_wr
);

    logic [NUM_REGS*AXI_DATA_WIDTH-1:0] w_reg_flat;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic [AXI_DATA_WIDTH-1:0] r_reg;
        logic                      r_wr;
        logic                      w_sel;

        assign w_sel = i_wr_en && (i_wr_idx == IDX_W'(i));

        // The update strobe fires on any commit to this register, including
        // an all-zero strobe that leaves the contents unchanged.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_reg <= RESET_VAL;
                r_wr  <= 1'b0;
            end else begin
                r_wr <= w_sel;
                if (w_sel) begin
                    r_reg <= strb_merge(r_reg, i_wr_data, i_wr_strb);
                end
            end
        end

        assign w_reg_flat[AXI_DATA_WIDTH*i +: AXI_DATA_WIDTH] = r_reg;
        assign o_reg_wr[i] = r_wr;
    end

    // Reads see the pre-edge contents, so a read captured on the same edge
    // as a write commit returns the old value.
    always_comb begin
        o_rd_data = '0;
        for (int k = 0; k < int'(NUM_REGS); k++) begin
            if (i_rd_idx == IDX_W'(k)) begin
                o_rd_data = w_reg_flat[AXI_DATA_WIDTH*k +: AXI_DATA_WIDTH];
            end
        end
    end

    assign o_reg_out = w_reg_flat;

endmodule

`default_nettype wire

// File: rtl/axi_ddsv2_regs_slave.sv
// ============================================================================
// Module   : axi_ddsv2_regs_slave
// Purpose  : AXI4-Lite responder for the DDS v2 property registers. Holds the
//            independent write and read channel FSMs; storage lives in
//            axi_ddsv2_regs_bank.
// Ports    : ACLK, ARESET - clock, synchronous active-high reset
//            s_axi        - AXI4-Lite slave bundle (AW/W/B/AR/R)
//            reg_out      - register contents, reg i at [32i+31:32i]
//            reg_wr       - one-cycle pulse the cycle after reg i is written
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_ddsv2_regs_slave
    import axi_ddsv2_regs_pkg::*;
#(
    parameter int unsigned               NUM_REGS   = 4,
    parameter int                        ADDR_WIDTH = 5,
    parameter logic [AXI_DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  wire logic                               ACLK,
    input  wire logic                               ARESET,
    axi_ddsv2_regs_if.slave                         s_axi,
    output logic [NUM_REGS*AXI_DATA_WIDTH-1:0]      reg_out,
    output logic [NUM_REGS-1:0]                     reg_wr
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    // Ready outputs are gated by this flag so they stay low throughout reset
    // and rise on the first cycle after it is released.
    logic r_ready_en;

    always_ff @(posedge ACLK) begin
        if (ARESET) r_ready_en <= 1'b0;
        else        r_ready_en <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_t                  r_w_state, w_w_state_nxt;
    logic                      r_aw_done, r_w_done;
    logic [IDX_W-1:0]          r_aw_idx;
    logic [AXI_DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0]     r_wstrb;
    logic [1:0]                r_bresp;

    logic                      w_awready, w_wready, w_bvalid;
    logic                      w_aw_hs, w_w_hs, w_commit, w_wr_in_range;
    logic [IDX_W-1:0]          w_wr_idx;
    logic [AXI_DATA_WIDTH-1:0] w_wr_data;
    logic [STRB_WIDTH-1:0]     w_wr_strb;

    assign w_aw_hs = s_axi.S_AXI_AWVALID && w_awready;
    assign w_w_hs  = s_axi.S_AXI_WVALID  && w_wready;

    // Commit on the edge where both halves are in hand, whether captured
    // earlier or handshaking right now.
    assign w_commit = (r_w_state == W_IDLE) &&
                      (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

    assign w_wr_idx  = r_aw_done ? r_aw_idx : s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2];
    assign w_wr_data = r_w_done  ? r_wdata  : s_axi.S_AXI_WDATA;
    assign w_wr_strb = r_w_done  ? r_wstrb  : s_axi.S_AXI_WSTRB;
    assign w_wr_in_range = (32'(w_wr_idx) < NUM_REGS);

    always_ff @(posedge ACLK) begin
        if (ARESET) r_w_state <= W_IDLE;
        else        r_w_state <= w_w_state_nxt;
    end

    always_comb begin
        w_w_state_nxt = r_w_state;
        case (r_w_state)
            W_IDLE:  if (w_commit)             w_w_state_nxt = W_RESP;
            W_RESP:  if (s_axi.S_AXI_BREADY)   w_w_state_nxt = W_IDLE;
            default:                           w_w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_awready = r_ready_en && (r_w_state == W_IDLE) && !r_aw_done;
        w_wready  = r_ready_en && (r_w_state == W_IDLE) && !r_w_done;
        w_bvalid  = (r_w_state == W_RESP);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= RESP_OKAY;
        end else if (w_commit) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bresp   <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
                r_aw_idx  <= s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2];
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
                r_wdata  <= s_axi.S_AXI_WDATA;
                r_wstrb  <= s_axi.S_AXI_WSTRB;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_t                  r_r_state, w_r_state_nxt;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]                r_rresp;
    logic                      w_arready, w_rvalid, w_ar_hs, w_rd_in_range;
    logic [IDX_W-1:0]          w_rd_idx;
    logic [AXI_DATA_WIDTH-1:0] w_rd_data;

    assign w_ar_hs       = s_axi.S_AXI_ARVALID && w_arready;
    assign w_rd_idx      = s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign w_rd_in_range = (32'(w_rd_idx) < NUM_REGS);

    always_ff @(posedge ACLK) begin
        if (ARESET) r_r_state <= R_IDLE;
        else        r_r_state <= w_r_state_nxt;
    end

    always_comb begin
        w_r_state_nxt = r_r_state;
        case (r_r_state)
            R_IDLE:  if (w_ar_hs)            w_r_state_nxt = R_DATA;
            R_DATA:  if (s_axi.S_AXI_RREADY) w_r_state_nxt = R_IDLE;
            default:                         w_r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_arready = r_ready_en && (r_r_state == R_IDLE);
        w_rvalid  = (r_r_state == R_DATA);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rdata <= w_rd_in_range ? w_rd_data : '0;
            r_rresp <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    axi_ddsv2_regs_bank #(
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W),
        .RESET_VAL (RESET_VAL)
    ) u_bank (
        .clk       (ACLK),
        .rst       (ARESET),
        .i_wr_en   (w_commit && w_wr_in_range),
        .i_wr_idx  (w_wr_idx),
        .i_wr_data (w_wr_data),
        .i_wr_strb (w_wr_strb),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data),
        .o_reg_out (reg_out),
        .o_reg_wr  (reg_wr)
    );

    assign s_axi.S_AXI_AWREADY = w_awready;
    assign s_axi.S_AXI_WREADY  = w_wready;
    assign s_axi.S_AXI_BVALID  = w_bvalid;
    assign s_axi.S_AXI_BRESP   = r_bresp;
    assign s_axi.S_AXI_ARREADY = w_arready;
    assign s_axi.S_AXI_RVALID  = w_rvalid;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = r_rresp;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic w_unused;
    assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_axi_ddsv2_regs_slave.sv
// ============================================================================
// Module   : tb_axi_ddsv2_regs_slave
// Purpose  : Self-checking bench for axi_ddsv2_regs_slave. Stimulus pushes the
//            expected B/R responses into queues; monitors pop and compare on
//            every completed response handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_ddsv2_regs_slave;
    import axi_ddsv2_regs_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] reg_out;
    logic [3:0]   reg_wr;

    always #5 clk = ~clk;

    axi_ddsv2_regs_if #(.ADDR_WIDTH(5)) bus ();

    axi_ddsv2_regs_slave #(
        .NUM_REGS   (4),
        .ADDR_WIDTH (5),
        .RESET_VAL  (32'h0)
    ) dut (
        .ACLK    (clk),
        .ARESET  (rst),
        .s_axi   (bus.slave),
        .reg_out (reg_out),
        .reg_wr  (reg_wr)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    logic [1:0]  b_q [$];
    r_exp_t      r_q [$];
    logic [31:0] model [4];
    int          wr_cnt [4];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  b_exp;
    r_exp_t      r_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event did not occur", name);
    endtask

    // Response monitors
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
                if (b_q.size() == 0) fail_now("b_unexpected");
                else begin
                    b_exp = b_q.pop_front();
                    check("bresp", 32'(bus.S_AXI_BRESP), 32'(b_exp));
                end
            end
            if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
                if (r_q.size() == 0) fail_now("r_unexpected");
                else begin
                    r_exp = r_q.pop_front();
                    check("rdata", bus.S_AXI_RDATA, r_exp.data);
                    check("rresp", 32'(bus.S_AXI_RRESP), 32'(r_exp.resp));
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (reg_wr[i] === 1'b1) wr_cnt[i]++;
    end

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_reg%0d", tag, i), reg_out[32*i +: 32], model[i]);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((b_q.size() != 0 || r_q.size() != 0) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) fail_now("drain_timeout");
    endtask

    // Starts and ends one time unit after a rising edge.
    task automatic do_write(input logic [4:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input logic [1:0] resp, input bit drain);
        bit aw_done = 0;
        bit w_done  = 0;
        int c = 0;
        b_q.push_back(resp);
        bus.S_AXI_AWADDR = addr;
        bus.S_AXI_WDATA  = data;
        bus.S_AXI_WSTRB  = strb;
        while (!(aw_done && w_done) && c < 50) begin
            bus.S_AXI_AWVALID = !aw_done && (c >= aw_dly);
            bus.S_AXI_WVALID  = !w_done  && (c >= w_dly);
            @(negedge clk);
            if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) aw_done = 1;
            if (bus.S_AXI_WVALID  && bus.S_AXI_WREADY)  w_done  = 1;
            @(posedge clk); #1; c++;
        end
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        if (c >= 50) fail_now("write_handshake_timeout");
        if (drain) wait_drain();
    endtask

    task automatic do_read(input logic [4:0] addr, input logic [31:0] data, input logic [1:0] resp);
        bit got = 0;
        int c = 0;
        r_q.push_back('{data: data, resp: resp});
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        while (!got && c < 50) begin
            @(negedge clk);
            if (bus.S_AXI_ARREADY) got = 1;
            @(posedge clk); #1; c++;
        end
        bus.S_AXI_ARVALID = 1'b0;
        if (!got) fail_now("read_handshake_timeout");
        wait_drain();
    endtask

    initial begin
        rst = 1'b1;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY = 1'b1;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin model[i] = 32'h0; wr_cnt[i] = 0; end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_awready", 32'(bus.S_AXI_AWREADY), 0);
        check("rst_wready",  32'(bus.S_AXI_WREADY), 0);
        check("rst_arready", 32'(bus.S_AXI_ARREADY), 0);
        check("rst_bvalid",  32'(bus.S_AXI_BVALID), 0);
        check("rst_rvalid",  32'(bus.S_AXI_RVALID), 0);
        check("rst_bresp",   32'(bus.S_AXI_BRESP), 0);
        check("rst_rresp",   32'(bus.S_AXI_RRESP), 0);
        check("rst_rdata",   bus.S_AXI_RDATA, 0);
        check("rst_reg_wr",  32'(reg_wr), 0);
        check_regs("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("arready_before_release_edge", 32'(bus.S_AXI_ARREADY), 0);
        @(posedge clk); #1;
        check("ready_after_reset", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 32'h7);

        // Basic writes and readback
        do_write(5'h00, 32'h1, 4'hF, 0, 0, RESP_OKAY, 1); model[0] = 32'h1;
        do_write(5'h04, 32'h2, 4'hF, 0, 0, RESP_OKAY, 1); model[1] = 32'h2;
        do_write(5'h08, 32'h3, 4'hF, 0, 0, RESP_OKAY, 1); model[2] = 32'h3;
        do_write(5'h0C, 32'h4, 4'hF, 0, 0, RESP_OKAY, 1); model[3] = 32'h4;
        check_regs("basic");
        do_read(5'h00, 32'h1, RESP_OKAY);
        do_read(5'h04, 32'h2, RESP_OKAY);
        do_read(5'h08, 32'h3, RESP_OKAY);
        do_read(5'h0C, 32'h4, RESP_OKAY);
        for (int i = 0; i < 4; i++) check($sformatf("basic_wr_cnt%0d", i), wr_cnt[i], 1);

        // Partial strobe
        do_write(5'h04, 32'hAABBCCDD, 4'b0101, 0, 0, RESP_OKAY, 1); model[1] = 32'h00BB00DD;
        do_read(5'h04, 32'h00BB00DD, RESP_OKAY);
        check("strb_wr_cnt1", wr_cnt[1], 2);

        // W leads AW by three cycles, response stalled for five cycles
        bus.S_AXI_BREADY = 1'b0;
        do_write(5'h00, 32'h11, 4'hF, 3, 0, RESP_OKAY, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("wlead_hold%0d", k),
                  32'({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 32'h4);
            @(posedge clk); #1;
        end
        bus.S_AXI_BREADY = 1'b1;
        wait_drain();
        model[0] = 32'h11;
        check("wlead_wr_cnt0", wr_cnt[0], 2);

        // AW leads W by three cycles, response stalled for five cycles
        bus.S_AXI_BREADY = 1'b0;
        do_write(5'h00, 32'h22, 4'hF, 0, 3, RESP_OKAY, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("awlead_hold%0d", k),
                  32'({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 32'h4);
            @(posedge clk); #1;
        end
        bus.S_AXI_BREADY = 1'b1;
        wait_drain();
        model[0] = 32'h22;
        check("awlead_wr_cnt0", wr_cnt[0], 3);
        do_read(5'h00, 32'h22, RESP_OKAY);

        // Out-of-range index 4
        do_write(5'h10, 32'hDEADBEEF, 4'hF, 0, 0, RESP_SLVERR, 1);
        do_read(5'h10, 32'h0, RESP_SLVERR);
        check_regs("oor");
        check("oor_wr_cnt", wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3], 3 + 2 + 1 + 1);

        // Write commit and read handshake to 0x8 on the same edge
        b_q.push_back(RESP_OKAY);
        r_q.push_back('{data: 32'h3, resp: RESP_OKAY});
        bus.S_AXI_AWADDR = 5'h08; bus.S_AXI_WDATA = 32'h7; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_ARADDR = 5'h08;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        check("same_edge_readies",
              32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 32'h7);
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        wait_drain();
        model[2] = 32'h7;
        do_read(5'h08, 32'h7, RESP_OKAY);

        // Reset while a read response is pending
        bus.S_AXI_RREADY  = 1'b0;
        bus.S_AXI_ARADDR  = 5'h0C;
        bus.S_AXI_ARVALID = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_ARVALID = 1'b0;
        @(negedge clk);
        check("pending_rvalid", 32'(bus.S_AXI_RVALID), 1);
        check("pending_rdata", bus.S_AXI_RDATA, 32'h4);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
        check("midrst_rvalid", 32'(bus.S_AXI_RVALID), 0);
        check("midrst_arready", 32'(bus.S_AXI_ARREADY), 0);
        check_regs("midrst");
        rst = 1'b0;
        @(posedge clk); #1;
        check("postrst_arready", 32'(bus.S_AXI_ARREADY), 1);
        check("postrst_rvalid", 32'(bus.S_AXI_RVALID), 0);
        bus.S_AXI_RREADY = 1'b1;
        do_read(5'h0C, 32'h0, RESP_OKAY);

        check("final_b_q_empty", 32'(b_q.size()), 0);
        check("final_r_q_empty", 32'(r_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
